fe_fifo_decoder: RTL and testbench

- Read side of the front-end capture FIFO, clocked in the cwusb_clk domain.
- Pops 18-bit capture words and decodes DATA, STAT and TIME commands.
- Rebuilds an absolute 32-bit timestamp from the short and full time deltas.
- Presents one decoded event per DATA/STAT word on a valid/ready stream, for the USB streaming path and on-chip consumers.

---
 rtl/fe_fifo_decoder.sv | 179 +++++++++++++++++
 tb/tb_fe_fifo_decoder.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fe_fifo_decoder.sv
// Read side of the front-end capture FIFO: pops 18-bit capture words, rebuilds an
// absolute timestamp from TIME/short deltas and streams DATA/STAT events out.
module fe_fifo_decoder #(
    parameter int pTIMESTAMP_FULL_WIDTH  = 16,
    parameter int pTIMESTAMP_SHORT_WIDTH = 3,
    parameter int pABS_TIME_WIDTH        = 32
) (
    input  logic                       cwusb_clk,
    input  logic                       reset_n,
    input  logic                       I_flush,
    input  logic                       I_drop_stat,
    input  logic                       I_fifo_empty,
    input  logic [17:0]                I_fifo_dout,
    output logic                       O_fifo_rd,
    output logic                       O_ev_valid,
    input  logic                       I_ev_ready,
    output logic                       O_ev_is_data,
    output logic [7:0]                 O_ev_data,
    output logic [4:0]                 O_ev_status,
    output logic [pABS_TIME_WIDTH-1:0] O_ev_time,
    output logic [23:0]                O_event_count,
    output logic                       O_err_badcmd,
    output logic                       O_err_time_wrap
);
    localparam int EW = 1 + 8 + 5 + pABS_TIME_WIDTH;

    localparam logic [1:0] CMD_DATA = 2'b00;
    localparam logic [1:0] CMD_TIME = 2'b01;
    localparam logic [1:0] CMD_STAT = 2'b10;
    localparam logic [1:0] CMD_BAD  = 2'b11;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_t;

    // Reset asserts asynchronously but releases only after two clean clock edges.
    logic [1:0] rst_sync_reg;
    logic       rst_n;

    always_ff @(posedge cwusb_clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_reg <= 2'b00;
        end else begin
            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_reg[1];

    buf_state_t                 buf_state_reg;
    logic                       rd_inflight_reg;
    logic                       flush_d_reg;
    logic [pABS_TIME_WIDTH-1:0] acc_reg;
    logic [EW-1:0]              main_reg;
    logic [EW-1:0]              skid_reg;
    logic [23:0]                count_reg;
    logic                       badcmd_reg;
    logic                       wrap_reg;

    logic [1:0]                 cmd;
    logic [pABS_TIME_WIDTH-1:0] delta;
    logic [pABS_TIME_WIDTH:0]   sum;
    logic                       accept;
    logic                       push;
    logic                       pop;
    logic [2:0]                 occ_sum;
    logic [EW-1:0]              ev_next;

    assign cmd = I_fifo_dout[1:0];

    always_comb begin
        delta = '0;
        if (cmd == CMD_TIME) begin
            delta[pTIMESTAMP_FULL_WIDTH-1:0] = I_fifo_dout[2 +: pTIMESTAMP_FULL_WIDTH];
        end else begin
            delta[pTIMESTAMP_SHORT_WIDTH-1:0] = I_fifo_dout[2 +: pTIMESTAMP_SHORT_WIDTH];
        end
    end

    assign sum = {1'b0, acc_reg} + {1'b0, delta};

    // A word landing in the flush cycle or right after it belongs to the old stream.
    assign accept = rd_inflight_reg && !I_flush && !flush_d_reg;
    assign push   = accept && ((cmd == CMD_DATA) || ((cmd == CMD_STAT) && !I_drop_stat));
    assign pop    = O_ev_valid && I_ev_ready;

    assign ev_next = {(cmd == CMD_DATA),
                      (cmd == CMD_DATA) ? I_fifo_dout[12:5] : 8'h00,
                      I_fifo_dout[17:13],
                      sum[pABS_TIME_WIDTH-1:0]};

    assign occ_sum   = {1'b0, buf_state_reg} + {2'b00, rd_inflight_reg};
    assign O_fifo_rd = rst_n && !I_fifo_empty && !I_flush && (occ_sum < 3'd2);

    always_ff @(posedge cwusb_clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_state_reg   <= BUF_EMPTY;
            rd_inflight_reg <= 1'b0;
            flush_d_reg     <= 1'b0;
            acc_reg         <= '0;
            main_reg        <= '0;
            skid_reg        <= '0;
            count_reg       <= '0;
            badcmd_reg      <= 1'b0;
            wrap_reg        <= 1'b0;
        end else if (I_flush) begin
            buf_state_reg   <= BUF_EMPTY;
            rd_inflight_reg <= 1'b0;
            flush_d_reg     <= 1'b1;
            acc_reg         <= '0;
            main_reg        <= '0;
            skid_reg        <= '0;
            count_reg       <= '0;
            badcmd_reg      <= 1'b0;
            wrap_reg        <= 1'b0;
        end else begin
            rd_inflight_reg <= O_fifo_rd;
            flush_d_reg     <= 1'b0;

            if (accept) begin
                if (cmd == CMD_BAD) begin
                    badcmd_reg <= 1'b1;
                end else begin
                    acc_reg <= sum[pABS_TIME_WIDTH-1:0];
                    if (sum[pABS_TIME_WIDTH]) begin
                        wrap_reg <= 1'b1;
                    end
                end
            end

            if (pop && (count_reg != 24'hFF_FFFF)) begin
                count_reg <= count_reg + 24'd1;
            end

            case (buf_state_reg)
                BUF_EMPTY: begin
                    if (push) begin
                        main_reg      <= ev_next;
                        buf_state_reg <= BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    case ({push, pop})
                        2'b10: begin
                            skid_reg      <= ev_next;
                            buf_state_reg <= BUF_FULL;
                        end
                        2'b01: buf_state_reg <= BUF_EMPTY;
                        2'b11: main_reg <= ev_next;
                        default: ;
                    endcase
                end
                BUF_FULL: begin
                    if (pop) begin
                        main_reg <= skid_reg;
                        if (push) begin
                            skid_reg <= ev_next;
                        end else begin
                            buf_state_reg <= BUF_ONE;
                        end
                    end
                end
                default: buf_state_reg <= BUF_EMPTY;
            endcase
        end
    end

    assign O_ev_valid      = (buf_state_reg != BUF_EMPTY);
    assign O_ev_is_data    = main_reg[EW-1];
    assign O_ev_data       = main_reg[EW-2 -: 8];
    assign O_ev_status     = main_reg[pABS_TIME_WIDTH +: 5];
    assign O_ev_time       = main_reg[pABS_TIME_WIDTH-1:0];
    assign O_event_count   = count_reg;
    assign O_err_badcmd    = badcmd_reg;
    assign O_err_time_wrap = wrap_reg;

endmodule

// File: tb/tb_fe_fifo_decoder.sv
// Bench for fe_fifo_decoder: FIFO model, vector table, corner sequences and a
// randomized run scored against a queue-based timestamp/event model.
module tb_fe_fifo_decoder;

    logic        cwusb_clk;
    logic        reset_n;
    logic        I_flush;
    logic        I_drop_stat;
    logic        I_fifo_empty;
    logic [17:0] I_fifo_dout;
    logic        I_ev_ready;

    logic        O_fifo_rd, O_ev_valid, O_ev_is_data, O_err_badcmd, O_err_time_wrap;
    logic [7:0]  O_ev_data;
    logic [4:0]  O_ev_status;
    logic [31:0] O_ev_time;
    logic [23:0] O_event_count;

    // Narrow-timestamp twin on the same stimulus, so wrap is reachable quickly.
    logic        b_rd, b_valid, b_is_data, b_bad, b_wrap;
    logic [7:0]  b_data;
    logic [4:0]  b_status;
    logic [19:0] b_time;
    logic [23:0] b_count;

    fe_fifo_decoder dut (
        .cwusb_clk(cwusb_clk), .reset_n(reset_n), .I_flush(I_flush),
        .I_drop_stat(I_drop_stat), .I_fifo_empty(I_fifo_empty), .I_fifo_dout(I_fifo_dout),
        .O_fifo_rd(O_fifo_rd), .O_ev_valid(O_ev_valid), .I_ev_ready(I_ev_ready),
        .O_ev_is_data(O_ev_is_data), .O_ev_data(O_ev_data), .O_ev_status(O_ev_status),
        .O_ev_time(O_ev_time), .O_event_count(O_event_count),
        .O_err_badcmd(O_err_badcmd), .O_err_time_wrap(O_err_time_wrap)
    );

    fe_fifo_decoder #(.pABS_TIME_WIDTH(20)) dut_b (
        .cwusb_clk(cwusb_clk), .reset_n(reset_n), .I_flush(I_flush),
        .I_drop_stat(I_drop_stat), .I_fifo_empty(I_fifo_empty), .I_fifo_dout(I_fifo_dout),
        .O_fifo_rd(b_rd), .O_ev_valid(b_valid), .I_ev_ready(I_ev_ready),
        .O_ev_is_data(b_is_data), .O_ev_data(b_data), .O_ev_status(b_status),
        .O_ev_time(b_time), .O_event_count(b_count),
        .O_err_badcmd(b_bad), .O_err_time_wrap(b_wrap)
    );

    initial cwusb_clk = 1'b0;
    always #5 cwusb_clk = ~cwusb_clk;

    typedef struct packed {
        logic        is_data;
        logic [7:0]  data;
        logic [4:0]  status;
        logic [31:0] tm;
    } ev_t;

    typedef struct {
        logic        flush;
        logic        drop;
        logic [17:0] word;
        int          n_ev;
        logic        is_data;
        logic [7:0]  data;
        logic [4:0]  status;
        logic [31:0] tm;
        logic [23:0] cnt;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    logic [17:0] fifo_q[$];
    ev_t         exp_q[$];
    ev_t         got[$];
    logic [19:0] got_b[$];

    logic        s_rd, s_v, hold_v, track_en, prev_emit;
    ev_t         snap;
    int          m_occ, m_infl, m_count;
    logic [31:0] m_acc;
    logic        m_wrap, m_bad;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic logic [17:0] mk(input logic [1:0] cmd, input logic [2:0] t,
                                       input logic [7:0] d, input logic [4:0] st);
        return {st, d, t, cmd};
    endfunction

    function automatic logic [17:0] mk_time(input logic [15:0] dt);
        return {dt, 2'b01};
    endfunction

    task automatic model_word(input logic [17:0] w);
        logic [32:0] sum;
        ev_t e;
        if (w[1:0] == 2'b11) begin
            m_bad = 1'b1;
            return;
        end
        if (w[1:0] == 2'b01) sum = {1'b0, m_acc} + {17'd0, w[17:2]};
        else                 sum = {1'b0, m_acc} + {30'd0, w[4:2]};
        if (sum[32]) m_wrap = 1'b1;
        m_acc = sum[31:0];
        if (w[1:0] == 2'b00 || (w[1:0] == 2'b10 && !I_drop_stat)) begin
            e.is_data = (w[1:0] == 2'b00);
            e.data    = e.is_data ? w[12:5] : 8'h00;
            e.status  = w[17:13];
            e.tm      = m_acc;
            exp_q.push_back(e);
        end
    endtask

    task automatic push_raw(input logic [17:0] w);
        fifo_q.push_back(w);
        I_fifo_empty = 1'b0;
    endtask

    task automatic push_word(input logic [17:0] w);
        push_raw(w);
        model_word(w);
    endtask

    // One clock: entered at a negedge with inputs set, returns at the next negedge.
    task automatic tick();
        ev_t cur;
        logic [17:0] w;
        #4;
        s_rd = O_fifo_rd;
        s_v  = O_ev_valid;
        cur  = {O_ev_is_data, O_ev_data, O_ev_status, O_ev_time};
        if (track_en) begin
            check("rd_rule", s_rd, !I_fifo_empty && !I_flush && (m_occ + m_infl) < 2);
            check("valid_occ", s_v, m_occ != 0);
        end
        if (hold_v) check("stall_hold", {s_v, cur}, {1'b1, snap});
        hold_v = s_v && !I_ev_ready && !I_flush;
        snap   = cur;
        if (s_v && I_ev_ready) got.push_back(cur);
        if (b_valid && I_ev_ready) got_b.push_back(b_time);
        if (I_flush) begin
            m_occ = 0; m_infl = 0; prev_emit = 1'b0;
        end else begin
            m_occ  = m_occ + ((m_infl != 0 && prev_emit) ? 1 : 0) - ((s_v && I_ev_ready) ? 1 : 0);
            m_infl = s_rd ? 1 : 0;
        end
        @(negedge cwusb_clk);
        if (s_rd && fifo_q.size() > 0) begin
            w = fifo_q.pop_front();
            I_fifo_dout = w;
            prev_emit = (w[1:0] == 2'b00) || (w[1:0] == 2'b10 && !I_drop_stat);
        end else begin
            I_fifo_dout = 18'($urandom);
        end
        I_fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic drain();
        int idle = 0;
        I_ev_ready = 1'b1;
        for (int k = 0; k < 300 && idle < 3; k++) begin
            tick();
            if (fifo_q.size() == 0 && !O_ev_valid && !s_rd) idle++;
            else idle = 0;
        end
        if (idle < 3) check("drain_timeout", 0, 1);
    endtask

    task automatic model_clear();
        m_acc = '0; m_wrap = 1'b0; m_bad = 1'b0; m_count = 0;
        exp_q.delete(); got.delete(); got_b.delete();
    endtask

    task automatic do_flush();
        I_flush = 1'b1;
        tick();
        I_flush = 1'b0;
        model_clear();
    endtask

    task automatic compare_events(input string tag);
        ev_t e, g;
        check({tag, "_nev"}, got.size(), exp_q.size());
        m_count += exp_q.size();
        while (exp_q.size() > 0 && got.size() > 0) begin
            e = exp_q.pop_front();
            g = got.pop_front();
            check({tag, "_is_data"}, g.is_data, e.is_data);
            check({tag, "_data"}, g.data, e.data);
            check({tag, "_status"}, g.status, e.status);
            check({tag, "_time"}, g.tm, e.tm);
        end
        exp_q.delete();
        got.delete();
        check({tag, "_count"}, O_event_count, m_count);
        check({tag, "_badcmd"}, O_err_badcmd, m_bad);
        check({tag, "_wrap"}, O_err_time_wrap, m_wrap);
    endtask

    task automatic start_tracking_after_reset();
        fifo_q.delete();
        I_fifo_empty = 1'b1;
        m_occ = 0; m_infl = 0; prev_emit = 1'b0; hold_v = 1'b0; track_en = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        track_en = 1'b1;
        model_clear();
    endtask

    function automatic logic [17:0] rand_word();
        int r;
        r = $urandom_range(0, 99);
        if (r < 50)      return mk(2'b00, 3'($urandom), 8'($urandom), 5'($urandom));
        else if (r < 75) return mk(2'b10, 3'($urandom), 8'($urandom), 5'($urandom));
        else if (r < 90) return mk_time(16'($urandom));
        else             return {16'($urandom), 2'b11};
    endfunction

    vec_t vt[9];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ev_t g;

        vt[0] = '{1'b0, 1'b0, mk(2'b00, 3'd3, 8'hA5, 5'h04), 1, 1'b1, 8'hA5, 5'h04, 32'd3,      24'd1};
        vt[1] = '{1'b0, 1'b0, mk(2'b00, 3'd1, 8'h5A, 5'h00), 1, 1'b1, 8'h5A, 5'h00, 32'd4,      24'd2};
        vt[2] = '{1'b1, 1'b0, mk_time(16'h1234),             0, 1'b0, 8'h00, 5'h00, 32'd0,      24'd0};
        vt[3] = '{1'b0, 1'b0, mk(2'b00, 3'd0, 8'h11, 5'h03), 1, 1'b1, 8'h11, 5'h03, 32'h1234,   24'd1};
        vt[4] = '{1'b1, 1'b0, mk(2'b10, 3'd2, 8'hFF, 5'h1F), 1, 1'b0, 8'h00, 5'h1F, 32'd2,      24'd1};
        vt[5] = '{1'b0, 1'b1, mk(2'b10, 3'd2, 8'hFF, 5'h1F), 0, 1'b0, 8'h00, 5'h00, 32'd0,      24'd1};
        vt[6] = '{1'b0, 1'b0, mk(2'b00, 3'd0, 8'h22, 5'h00), 1, 1'b1, 8'h22, 5'h00, 32'd4,      24'd2};
        vt[7] = '{1'b0, 1'b0, mk_time(16'h0010),             0, 1'b0, 8'h00, 5'h00, 32'd0,      24'd2};
        vt[8] = '{1'b0, 1'b0, mk(2'b00, 3'd7, 8'hC3, 5'h0A), 1, 1'b1, 8'hC3, 5'h0A, 32'h1B,     24'd3};

        reset_n = 1'b0; I_flush = 1'b0; I_drop_stat = 1'b0; I_fifo_empty = 1'b1;
        I_fifo_dout = '0; I_ev_ready = 1'b0;
        hold_v = 1'b0; track_en = 1'b0; prev_emit = 1'b0; m_occ = 0; m_infl = 0;
        model_clear();
        @(negedge cwusb_clk);
        @(negedge cwusb_clk);
        check("rst_valid", O_ev_valid, 0);
        check("rst_rd", O_fifo_rd, 0);
        check("rst_count", O_event_count, 0);
        check("rst_time", O_ev_time, 0);
        check("rst_errs", {O_err_badcmd, O_err_time_wrap}, 0);
        reset_n = 1'b1;
        start_tracking_after_reset();

        // Vector table, one word per record, state carries across records.
        for (int i = 0; i < 9; i++) begin
            if (vt[i].flush) do_flush();
            I_drop_stat = vt[i].drop;
            push_raw(vt[i].word);
            drain();
            check($sformatf("vec%0d_nev", i), got.size(), vt[i].n_ev);
            if (vt[i].n_ev == 1 && got.size() == 1) begin
                g = got.pop_front();
                check($sformatf("vec%0d_is_data", i), g.is_data, vt[i].is_data);
                check($sformatf("vec%0d_data", i), g.data, vt[i].data);
                check($sformatf("vec%0d_status", i), g.status, vt[i].status);
                check($sformatf("vec%0d_time", i), g.tm, vt[i].tm);
            end
            got.delete();
            check($sformatf("vec%0d_count", i), O_event_count, vt[i].cnt);
            check($sformatf("vec%0d_errs", i), {O_err_badcmd, O_err_time_wrap}, 0);
        end
        I_drop_stat = 1'b0;

        // Eight back-to-back DATA words under a 1,0,0,1 ready pattern.
        do_flush();
        for (int i = 0; i < 8; i++) push_word(mk(2'b00, i[2:0], 8'h80 + 8'(i), i[4:0]));
        for (int k = 0; k < 48; k++) begin
            I_ev_ready = (k % 4 == 0) || (k % 4 == 3);
            tick();
        end
        drain();
        compare_events("b2b");
        check("b2b_total", O_event_count, 8);

        // Timestamp wrap on the 20-bit twin, then an illegal command.
        do_flush();
        for (int i = 0; i < 16; i++) push_word(mk_time(16'hFFFF));
        push_word(mk_time(16'h000E));
        push_word(mk(2'b00, 3'd3, 8'h33, 5'h05));
        drain();
        check("wrap_b_nev", got_b.size(), 1);
        if (got_b.size() > 0) check("wrap_b_time", got_b[0], 20'h00001);
        check("wrap_b_flag", b_wrap, 1);
        compare_events("wrap_a");
        got_b.delete();
        push_word({16'hABCD, 2'b11});
        push_word(mk(2'b00, 3'd0, 8'h44, 5'h00));
        drain();
        check("bad_b_flag", b_bad, 1);
        if (got_b.size() > 0) check("bad_b_time", got_b[0], 20'h00001);
        compare_events("bad");

        // Flush while one event is buffered and the next word is in flight.
        do_flush();
        I_ev_ready = 1'b0;
        push_raw(mk(2'b00, 3'd1, 8'h01, 5'h00));
        push_raw(mk(2'b00, 3'd2, 8'h02, 5'h00));
        push_raw(mk(2'b00, 3'd1, 8'h03, 5'h00));
        push_raw(mk(2'b00, 3'd2, 8'h04, 5'h00));
        tick();
        tick();
        check("pre_flush_valid", O_ev_valid, 1);
        I_flush = 1'b1;
        tick();
        I_flush = 1'b0;
        check("post_flush_valid", O_ev_valid, 0);
        check("post_flush_count", O_event_count, 0);
        model_clear();
        model_word(mk(2'b00, 3'd1, 8'h03, 5'h00));
        model_word(mk(2'b00, 3'd2, 8'h04, 5'h00));
        drain();
        compare_events("flush");

        // Reset pulse in the middle of traffic.
        for (int i = 0; i < 4; i++) push_raw(mk(2'b00, 3'd1, 8'hE0 + 8'(i), 5'h11));
        I_ev_ready = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        I_ev_ready = 1'b0;
        tick();
        tick();
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_valid", O_ev_valid, 0);
        check("mid_rst_rd", O_fifo_rd, 0);
        check("mid_rst_count", O_event_count, 0);
        check("mid_rst_fields", {O_ev_is_data, O_ev_data, O_ev_status, O_ev_time}, 0);
        check("mid_rst_errs", {O_err_badcmd, O_err_time_wrap}, 0);
        @(negedge cwusb_clk);
        reset_n = 1'b1;
        start_tracking_after_reset();

        // Randomized traffic against the reference model.
        for (int ph = 0; ph < 4; ph++) begin
            I_drop_stat = ph[0];
            for (int k = 0; k < 120; k++) begin
                if ($urandom_range(0, 2) != 0 && fifo_q.size() < 6) push_word(rand_word());
                I_ev_ready = ($urandom_range(0, 3) != 0);
                tick();
            end
            drain();
            compare_events($sformatf("rnd%0d", ph));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
